// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: buffers ALU result bytes in a small FIFO and streams
// them out over a UART line (8N1 by default, 8E1 when TX_PARITY_EN is defined).
// The tx line is registered from the FSM state, so it trails the state by one
// clock; bit boundaries are timed by a counter reloaded at each boundary.
`timescale 1ns/1ps

module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [AW:0]    r_count;
  logic [7:0]     r_shiftReg;
  logic [CW-1:0]  r_clkCnt;
  logic [2:0]     r_bitIdx;
  logic           r_tx;
`ifdef TX_PARITY_EN
  logic           r_parity;
`endif
  logic           w_push;
  logic           w_pop;
  logic           w_bitDone;
  logic           w_txNext;

  // Ready depends only on the registered count, so a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign in_ready   = (r_count != FULL);
  assign w_push     = in_valid && in_ready;
  assign w_bitDone  = (r_clkCnt == LAST_CLK);
  assign fifo_count = r_count;
  assign busy       = (r_state != IDLE) || (r_count != '0);
  assign tx         = r_tx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // Next-state, FIFO pop request and the line level for the current bit
  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_txNext    = 1'b1;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_stateNext = START;
        end
      end
      START: begin
        w_txNext = 1'b0;
        if (w_bitDone) w_stateNext = DATA;
      end
      DATA: begin
        w_txNext = r_shiftReg[0];
        if (w_bitDone && (r_bitIdx == 3'd7)) begin
`ifdef TX_PARITY_EN
          w_stateNext = PARITY;
`else
          w_stateNext = STOP;
`endif
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        w_txNext = r_parity;
        if (w_bitDone) w_stateNext = STOP;
      end
`endif
      STOP: begin
        w_txNext = 1'b1;
        if (w_bitDone) begin
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // FIFO storage, pointers, occupancy, bit timing, shift register and tx line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_clkCnt   <= '0;
      r_bitIdx   <= '0;
      r_shiftReg <= '0;
      r_tx       <= 1'b1;
`ifdef TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= in_data;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if ((r_state == IDLE) || w_bitDone) r_clkCnt <= '0;
      else                                r_clkCnt <= r_clkCnt + 1'b1;
      if (w_pop) begin
        r_shiftReg <= r_mem[r_rdPtr];
        r_bitIdx   <= '0;
`ifdef TX_PARITY_EN
        r_parity   <= ^r_mem[r_rdPtr];
`endif
      end else if ((r_state == DATA) && w_bitDone) begin
        r_shiftReg <= {1'b0, r_shiftReg[7:1]};
        r_bitIdx   <= r_bitIdx + 1'b1;
      end
      r_tx <= w_txNext;
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// tb_alu_result_uart_tx: directed bench for alu_result_uart_tx at
// CLKS_PER_BIT=4, FIFO_DEPTH=4. Inputs are driven and outputs sampled on the
// falling clock edge. Define TX_PARITY_EN for the 8E1 build.
`timescale 1ns/1ps

module tb_alu_result_uart_tx;

  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FC = FRAME_BITS * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int testsRun = 0;
  int testsFailed = 0;

  alu_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait never resolves
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    in_valid = valid;
    in_data  = data;
  endtask

  // Line level expected for bit slot k of a frame carrying byte d
  function automatic logic expBit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return d[k-1];
`ifdef TX_PARITY_EN
    else if (k == 9) return ^d;
`endif
    else return 1'b1;
  endfunction

  // Waits for a start bit, samples each bit mid-way and checks the frame
  task automatic checkFrame(input string tag, input logic [7:0] expData);
    int guard;
    logic [7:0] got;
    guard = 0;
    got = '0;
    while (tx !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_startSeen"}, 32'(guard < 2000), 32'd1);
    repeat (CPB / 2) @(negedge clk);
    checkOutput({tag, "_start"}, 32'(tx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      got[k] = tx;
    end
    checkOutput({tag, "_data"}, 32'(got), 32'(expData));
`ifdef TX_PARITY_EN
    repeat (CPB) @(negedge clk);
    checkOutput({tag, "_parity"}, 32'(tx), 32'(^expData));
`endif
    repeat (CPB) @(negedge clk);
    checkOutput({tag, "_stop"}, 32'(tx), 32'd1);
  endtask

  logic [7:0] t2Bytes [5];
  int expCount;

  // Directed sequence
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00);
    t2Bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);

    // Single byte 0xA5 into an idle block
    applyStimulus(1'b1, 8'hA5);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_countAfterPush", 32'(fifo_count), 32'd1);
    checkOutput("t1_busyAfterPush", 32'(busy), 32'd1);
    checkOutput("t1_txAfterPush", 32'(tx), 32'd1);
    @(negedge clk);
    checkOutput("t1_countAfterPop", 32'(fifo_count), 32'd0);
    checkOutput("t1_txBeforeStart", 32'(tx), 32'd1);
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      checkOutput("t1_tx", 32'(tx), 32'(expBit(8'hA5, i / CPB)));
      checkOutput("t1_busy", 32'(busy), 32'(i != FC - 1));
    end
    repeat (4) @(negedge clk);
    checkOutput("t1_txIdle", 32'(tx), 32'd1);
    checkOutput("t1_busyIdle", 32'(busy), 32'd0);

    // Five bytes back-to-back; FIFO fills to four, frames abut
    applyStimulus(1'b1, 8'h01);
    @(negedge clk);
    checkOutput("t2_count1", 32'(fifo_count), 32'd1);
    applyStimulus(1'b1, 8'h02);
    @(negedge clk);
    checkOutput("t2_countPushPop", 32'(fifo_count), 32'd1);
    applyStimulus(1'b1, 8'h03);
    @(negedge clk);
    checkOutput("t2_count2", 32'(fifo_count), 32'd2);
    checkOutput("t2_tx0", 32'(tx), 32'd0);
    applyStimulus(1'b1, 8'h04);
    @(negedge clk);
    checkOutput("t2_count3", 32'(fifo_count), 32'd3);
    checkOutput("t2_tx1", 32'(tx), 32'd0);
    applyStimulus(1'b1, 8'h05);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t2_count4", 32'(fifo_count), 32'd4);
    checkOutput("t2_readyFull", 32'(in_ready), 32'd0);
    checkOutput("t2_tx2", 32'(tx), 32'd0);
    for (int i = 3; i < 5 * FC; i++) begin
      @(negedge clk);
      expCount = 4 - (((i + 1) / FC) > 4 ? 4 : ((i + 1) / FC));
      checkOutput("t2_tx", 32'(tx), 32'(expBit(t2Bytes[i / FC], (i % FC) / CPB)));
      checkOutput("t2_count", 32'(fifo_count), 32'(expCount));
      checkOutput("t2_ready", 32'(in_ready), 32'(expCount != 4));
      checkOutput("t2_busy", 32'(busy), 32'(i != 5 * FC - 1));
    end

    // Full FIFO while the transmitter sits in the last stop-bit cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b1, 8'(8'h11 + b));
      @(negedge clk);
    end
    applyStimulus(1'b0, 8'h00);
    repeat (FC - 4) @(negedge clk);
    checkOutput("t3_countFull", 32'(fifo_count), 32'd4);
    checkOutput("t3_readyFull", 32'(in_ready), 32'd0);
    checkOutput("t3_txStop", 32'(tx), 32'd1);
    applyStimulus(1'b1, 8'h66);
    @(negedge clk);
    checkOutput("t3_countRefused", 32'(fifo_count), 32'd3);
    checkOutput("t3_readyAfterPop", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t3_countAccepted", 32'(fifo_count), 32'd4);
    checkFrame("t3_f12", 8'h12);
    checkFrame("t3_f13", 8'h13);
    checkFrame("t3_f14", 8'h14);
    checkFrame("t3_f15", 8'h15);
    checkFrame("t3_f66", 8'h66);
    repeat (FC) @(negedge clk);
    checkOutput("t3_busyEnd", 32'(busy), 32'd0);
    checkOutput("t3_countEnd", 32'(fifo_count), 32'd0);

    // Reset during data bit 3 of 0x00, with a push attempted under reset
    applyStimulus(1'b1, 8'h00);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    repeat (1 + 4 * CPB + 1) @(negedge clk);
    checkOutput("t4_txBeforeReset", 32'(tx), 32'd0);
    checkOutput("t4_busyBeforeReset", 32'(busy), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 8'hFF);
    @(negedge clk);
    checkOutput("t4_txReset", 32'(tx), 32'd1);
    checkOutput("t4_countReset", 32'(fifo_count), 32'd0);
    checkOutput("t4_busyReset", 32'(busy), 32'd0);
    checkOutput("t4_readyReset", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 3 * FC; i++) begin
      @(negedge clk);
      checkOutput("t4_txQuiet", 32'(tx), 32'd1);
      checkOutput("t4_busyQuiet", 32'(busy), 32'd0);
    end

`ifdef TX_PARITY_EN
    // Even parity: 0x07 carries parity 1, 0x03 carries parity 0
    applyStimulus(1'b1, 8'h07);
    @(negedge clk);
    applyStimulus(1'b1, 8'h03);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    checkFrame("t5_f07", 8'h07);
    checkFrame("t5_f03", 8'h03);
    repeat (FC) @(negedge clk);
    checkOutput("t5_busyEnd", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
